// File: rtl/target_game_ctrl.sv
// target_game_ctrl: VGA target game sequencer. It spawns up to N_SLOTS timed
// targets from an LFSR, hit-tests mouse clicks against them, keeps saturating
// hit/miss counters and issues draw/erase commands to one square drawer.
// Ports: clk/reset (sync, active-high); start (run level); click, click_x,
//   click_y (mouse); draw_req/draw_x0/draw_y0/draw_color out, draw_done in
//   (drawer command port); hit, score, misses, live (status outputs).
// Optional feature macro: SCORE_PENALTY_EN (a missed click in run mode costs a point).

// Purpose: game tick, target slots, click hit-test, counters, drawer sequencing.
// Latency: all outputs registered; hit/score/misses one edge after click/tick, draw_req >=1 cycle after pend flag.
// Backpressure: one drawer command at a time, draw_req held until draw_done; pending work queues in per-slot flags.
module target_game_ctrl #(
    parameter int N_SLOTS    = 2,
    parameter int TICK_DIV   = 131072,
    parameter int LIFE_TICKS = 8,
    parameter int SQ         = 16,
    parameter int X_MAX      = 624,
    parameter int Y_MAX      = 464,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               click,
    input  logic [10:0]        click_x,
    input  logic [10:0]        click_y,
    output logic               draw_req,
    output logic [10:0]        draw_x0,
    output logic [10:0]        draw_y0,
    output logic               draw_color,
    input  logic               draw_done,
    output logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [N_SLOTS-1:0] live
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [10:0]        X_MAX_L   = 11'(X_MAX);
    localparam logic [10:0]        Y_MAX_L   = 11'(Y_MAX);
    localparam logic [11:0]        SQ_L      = 12'(SQ);
    localparam logic [7:0]         LIFE_L    = 8'(LIFE_TICKS);
    localparam logic [SCORE_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {S_EMPTY, S_LIVE, S_ERASING} slot_st_t;
    typedef enum logic {D_IDLE, D_BUSY} draw_st_t;

    // state
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [19:0]        lfsr_q, lfsr_d;
    slot_st_t           st_q   [N_SLOTS];
    slot_st_t           st_d   [N_SLOTS];
    logic [10:0]        sx_q   [N_SLOTS];
    logic [10:0]        sx_d   [N_SLOTS];
    logic [10:0]        sy_q   [N_SLOTS];
    logic [10:0]        sy_d   [N_SLOTS];
    logic [7:0]         life_q [N_SLOTS];
    logic [7:0]         life_d [N_SLOTS];
    logic [N_SLOTS-1:0] pend_draw_q, pend_draw_d;
    logic [N_SLOTS-1:0] pend_erase_q, pend_erase_d;
    draw_st_t           dst_q, dst_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               draw_req_q, draw_req_d;
    logic [10:0]        draw_x0_q, draw_x0_d;
    logic [10:0]        draw_y0_q, draw_y0_d;
    logic               draw_color_q, draw_color_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic [N_SLOTS-1:0] live_q, live_d;

    // combinational helpers
    logic               tick;
    logic [10:0]        raw_x, raw_y, new_x0, new_y0;
    logic               found_e, found_d, launch_draw;
    logic [IDX_W-1:0]   idx_e, idx_d;
    logic [N_SLOTS-1:0] draw_svc;
    logic               hit_any, spawn_any;
    logic [IDX_W-1:0]   hit_idx, spawn_idx;
    logic [2:0]         miss_cnt;
    logic [SCORE_W+2:0] misses_sum;
    logic               expire, is_hit;

    assign tick = start && (tick_cnt_q == TICK_LAST);

    // Fold raw LFSR fields into the legal origin range. X_MAX>=511 and
    // Y_MAX>=255 guarantee one subtraction always lands in range.
    always_comb begin
        raw_x  = {1'b0, lfsr_q[9:0]};
        raw_y  = {2'b00, lfsr_q[18:10]};
        new_x0 = (raw_x > X_MAX_L) ? (raw_x - X_MAX_L - 11'd1) : raw_x;
        new_y0 = (raw_y > Y_MAX_L) ? (raw_y - Y_MAX_L - 11'd1) : raw_y;
    end

    // Drawer selection and the "draw in service" view used by removal.
    // A draw launched from D_IDLE this very cycle counts as in service so a
    // same-cycle hit cannot orphan the command being loaded.
    always_comb begin
        found_e  = 1'b0;
        found_d  = 1'b0;
        idx_e    = '0;
        idx_d    = '0;
        draw_svc = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (pend_erase_q[i]) begin
                found_e = 1'b1;
                idx_e   = IDX_W'(i);
            end
            if (pend_draw_q[i]) begin
                found_d = 1'b1;
                idx_d   = IDX_W'(i);
            end
        end
        launch_draw = (dst_q == D_IDLE) && !found_e && found_d;
        for (int i = 0; i < N_SLOTS; i++) begin
            draw_svc[i] = ((dst_q == D_BUSY) && draw_color_q && (sel_q == IDX_W'(i)))
                        || (launch_draw && (idx_d == IDX_W'(i)));
        end
    end

    // Lowest-index hit and lowest-index empty slot.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        spawn_any = 1'b0;
        spawn_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (click && start && (st_q[i] == S_LIVE)
                && ({1'b0, click_x} >= {1'b0, sx_q[i]})
                && ({1'b0, click_x} <  ({1'b0, sx_q[i]} + SQ_L))
                && ({1'b0, click_y} >= {1'b0, sy_q[i]})
                && ({1'b0, click_y} <  ({1'b0, sy_q[i]} + SQ_L))) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (st_q[i] == S_EMPTY) begin
                spawn_any = 1'b1;
                spawn_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        tick_cnt_d   = '0;
        lfsr_d       = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
        st_d         = st_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        life_d       = life_q;
        pend_draw_d  = pend_draw_q;
        pend_erase_d = pend_erase_q;
        dst_d        = dst_q;
        sel_d        = sel_q;
        draw_req_d   = draw_req_q;
        draw_x0_d    = draw_x0_q;
        draw_y0_d    = draw_y0_q;
        draw_color_d = draw_color_q;
        hit_d        = hit_any;
        score_d      = score_q;
        miss_cnt     = '0;
        expire       = 1'b0;
        is_hit       = 1'b0;

        if (start && !tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        for (int i = 0; i < N_SLOTS; i++) begin
            expire = 1'b0;
            is_hit = hit_any && (hit_idx == IDX_W'(i));
            if (tick && (st_q[i] == S_LIVE)) begin
                life_d[i] = life_q[i] - 8'd1;
                expire    = (life_q[i] == 8'd1);
            end
            if (is_hit || expire) begin
                // A hit on the expiry cycle scores rather than misses.
                if (!is_hit) begin
                    miss_cnt = miss_cnt + 3'd1;
                end
                if (pend_draw_q[i] && !draw_svc[i]) begin
                    pend_draw_d[i] = 1'b0;
                    st_d[i]        = S_EMPTY;
                end else begin
                    pend_erase_d[i] = 1'b1;
                    st_d[i]         = S_ERASING;
                end
            end
            // Only EMPTY slots spawn, so a slot removed this cycle never does.
            if (tick && spawn_any && (spawn_idx == IDX_W'(i))) begin
                st_d[i]        = S_LIVE;
                sx_d[i]        = new_x0;
                sy_d[i]        = new_y0;
                life_d[i]      = LIFE_L;
                pend_draw_d[i] = 1'b1;
            end
        end

        case (dst_q)
            D_IDLE: begin
                if (found_e) begin
                    sel_d        = idx_e;
                    draw_x0_d    = sx_q[idx_e];
                    draw_y0_d    = sy_q[idx_e];
                    draw_color_d = 1'b0;
                    draw_req_d   = 1'b1;
                    dst_d        = D_BUSY;
                end else if (found_d) begin
                    sel_d        = idx_d;
                    draw_x0_d    = sx_q[idx_d];
                    draw_y0_d    = sy_q[idx_d];
                    draw_color_d = 1'b1;
                    draw_req_d   = 1'b1;
                    dst_d        = D_BUSY;
                end
            end
            D_BUSY: begin
                if (draw_done) begin
                    draw_req_d = 1'b0;
                    dst_d      = D_IDLE;
                    if (draw_color_q) begin
                        pend_draw_d[sel_q] = 1'b0;
                    end else begin
                        pend_erase_d[sel_q] = 1'b0;
                        st_d[sel_q]         = S_EMPTY;
                    end
                end
            end
            default: dst_d = D_IDLE;
        endcase

        if (hit_any) begin
            if (score_q != CNT_MAX) begin
                score_d = score_q + 1'b1;
            end
        end
`ifdef SCORE_PENALTY_EN
        else if (click && start && (score_q != '0)) begin
            score_d = score_q - 1'b1;
        end
`endif

        misses_sum = {3'b000, misses_q} + {{SCORE_W{1'b0}}, miss_cnt};
        misses_d   = (misses_sum > {3'b000, CNT_MAX}) ? CNT_MAX : misses_sum[SCORE_W-1:0];

        for (int i = 0; i < N_SLOTS; i++) begin
            live_d[i] = (st_d[i] == S_LIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            lfsr_q       <= 20'h00001;
            for (int i = 0; i < N_SLOTS; i++) begin
                st_q[i]   <= S_EMPTY;
                sx_q[i]   <= '0;
                sy_q[i]   <= '0;
                life_q[i] <= '0;
            end
            pend_draw_q  <= '0;
            pend_erase_q <= '0;
            dst_q        <= D_IDLE;
            sel_q        <= '0;
            draw_req_q   <= 1'b0;
            draw_x0_q    <= '0;
            draw_y0_q    <= '0;
            draw_color_q <= 1'b0;
            hit_q        <= 1'b0;
            score_q      <= '0;
            misses_q     <= '0;
            live_q       <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            lfsr_q       <= lfsr_d;
            st_q         <= st_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            life_q       <= life_d;
            pend_draw_q  <= pend_draw_d;
            pend_erase_q <= pend_erase_d;
            dst_q        <= dst_d;
            sel_q        <= sel_d;
            draw_req_q   <= draw_req_d;
            draw_x0_q    <= draw_x0_d;
            draw_y0_q    <= draw_y0_d;
            draw_color_q <= draw_color_d;
            hit_q        <= hit_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            live_q       <= live_d;
        end
    end

    assign draw_req   = draw_req_q;
    assign draw_x0    = draw_x0_q;
    assign draw_y0    = draw_y0_q;
    assign draw_color = draw_color_q;
    assign hit        = hit_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign live       = live_q;

endmodule

// File: tb/tb_target_game_ctrl.sv
// Directed bench for target_game_ctrl: TICK_DIV=4, N_SLOTS=2, LIFE_TICKS=2,
// SCORE_W=2 so spawn, expiry, erase ordering and counter saturation all
// happen within a few dozen cycles. Cycle numbers below count from the first
// cycle after reset release (c0).
module tb_target_game_ctrl;
    localparam int XM = 624;
    localparam int YM = 464;

    logic        clk = 1'b0;
    logic        reset, start, click, draw_done;
    logic [10:0] click_x, click_y;
    logic        draw_req, draw_color, hit;
    logic [10:0] draw_x0, draw_y0;
    logic [1:0]  score, misses, live;

    int total = 0;
    int bad   = 0;
    int exp_score = 0;

    logic [19:0] m;
    logic [10:0] x0, y0, x1, y1, x2, y2, x3, y3, x5, y5;

    always #5 clk = ~clk;

    target_game_ctrl #(
        .N_SLOTS(2), .TICK_DIV(4), .LIFE_TICKS(2), .SQ(16),
        .X_MAX(XM), .Y_MAX(YM), .SCORE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .click(click),
        .click_x(click_x), .click_y(click_y),
        .draw_req(draw_req), .draw_x0(draw_x0), .draw_y0(draw_y0),
        .draw_color(draw_color), .draw_done(draw_done),
        .hit(hit), .score(score), .misses(misses), .live(live)
    );

    // Reference LFSR: x^20+x^17+1, seeded by reset, advancing every cycle.
    always @(posedge clk) begin
        if (reset) m <= 20'h00001;
        else       m <= {m[18:0], m[19] ^ m[16]};
    end

    function automatic logic [10:0] fx(input logic [19:0] v);
        logic [10:0] r;
        r = {1'b0, v[9:0]};
        if (r > 11'(XM)) r = r - 11'(XM) - 11'd1;
        return r;
    endfunction

    function automatic logic [10:0] fy(input logic [19:0] v);
        logic [10:0] r;
        r = {2'b00, v[18:10]};
        if (r > 11'(YM)) r = r - 11'(YM) - 11'd1;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; click = 1'b0; draw_done = 1'b0;
        click_x = '0; click_y = '0;
        step(3);
        reset = 1'b0; start = 1'b1;                       // c0
        chk("rst_req",    32'(draw_req),   32'd0);
        chk("rst_color",  32'(draw_color), 32'd0);
        chk("rst_hit",    32'(hit),        32'd0);
        chk("rst_score",  32'(score),      32'd0);
        chk("rst_misses", 32'(misses),     32'd0);
        chk("rst_live",   32'(live),       32'd0);

        step(3);                                          // c3: first tick
        x0 = fx(m); y0 = fy(m);
        step(1);                                          // c4
        chk("spawn0_live", 32'(live),     32'd1);
        chk("spawn0_noreq", 32'(draw_req), 32'd0);
        step(1);                                          // c5
        chk("draw0_req",   32'(draw_req),   32'd1);
        chk("draw0_x",     32'(draw_x0),    32'(x0));
        chk("draw0_y",     32'(draw_y0),    32'(y0));
        chk("draw0_color", 32'(draw_color), 32'd1);
        draw_done = 1'b1;
        step(1);                                          // c6
        chk("draw0_drop", 32'(draw_req), 32'd0);
        draw_done = 1'b0;
        step(1);                                          // c7: second tick
        x1 = fx(m); y1 = fy(m);
        step(1);                                          // c8
        chk("spawn1_live", 32'(live), 32'd3);
        step(1);                                          // c9
        chk("draw1_req", 32'(draw_req), 32'd1);
        chk("draw1_x",   32'(draw_x0),  32'(x1));

        click = 1'b1; click_x = x0 + 11'd15; click_y = y0 + 11'd15;
        step(1);                                          // c10
        exp_score = sat_inc(exp_score);
        chk("hit_corner",   32'(hit),   32'd1);
        chk("score_corner", 32'(score), 32'(exp_score));
        chk("live_after_hit", 32'(live), 32'd2);

        click_x = x1 + 11'd16; click_y = y1;              // just right of slot1
        step(1);                                          // c11
`ifdef SCORE_PENALTY_EN
        exp_score = (exp_score > 0) ? exp_score - 1 : 0;
`endif
        chk("miss_edge_hit",   32'(hit),   32'd0);
        chk("miss_edge_score", 32'(score), 32'(exp_score));
        click = 1'b0; draw_done = 1'b1;
        step(1);                                          // c12
        chk("draw1_drop", 32'(draw_req), 32'd0);
        draw_done = 1'b0;
        step(1);                                          // c13
        chk("erase0_req",   32'(draw_req),   32'd1);
        chk("erase0_color", 32'(draw_color), 32'd0);
        chk("erase0_x",     32'(draw_x0),    32'(x0));
        draw_done = 1'b1;
        step(1);                                          // c14
        chk("erase0_drop", 32'(draw_req), 32'd0);
        draw_done = 1'b0;
        step(1);                                          // c15: slot1 expires, slot0 respawns
        x2 = fx(m); y2 = fy(m);
        step(1);                                          // c16
        chk("expire1_misses", 32'(misses), 32'd1);
        chk("expire1_live",   32'(live),   32'd1);
        step(1);                                          // c17: erase beats pending draw
        chk("prio_req",   32'(draw_req),   32'd1);
        chk("prio_color", 32'(draw_color), 32'd0);
        chk("prio_x",     32'(draw_x0),    32'(x1));

        click = 1'b1; click_x = x2; click_y = y2;         // hit before its draw is served
        step(1);                                          // c18
        exp_score = sat_inc(exp_score);
        chk("early_hit",   32'(hit),   32'd1);
        chk("early_score", 32'(score), 32'(exp_score));
        chk("early_live",  32'(live),  32'd0);
        click = 1'b0; start = 1'b0; draw_done = 1'b1;
        step(1);                                          // c19
        chk("erase1_drop", 32'(draw_req), 32'd0);
        draw_done = 1'b0;
        step(1);                                          // c20
        chk("no_orphan_erase", 32'(draw_req), 32'd0);
        chk("paused_live",     32'(live),     32'd0);

        start = 1'b1; draw_done = 1'b1;                   // drawer always ready from here
        step(3);                                          // c23: spawn slot0
        x3 = fx(m); y3 = fy(m);
        step(8);                                          // c31: slot0 expiry tick
        click = 1'b1; click_x = x3 + 11'd7; click_y = y3 + 11'd3;
        step(1);                                          // c32
        exp_score = sat_inc(exp_score);
        chk("hit_on_expiry",       32'(hit),    32'd1);
        chk("hit_on_expiry_score", 32'(score),  32'(exp_score));
        chk("hit_on_expiry_miss",  32'(misses), 32'd1);
        chk("hit_on_expiry_live",  32'(live),   32'd2);
        click = 1'b0;
        step(4);                                          // c36
        chk("respawn_misses", 32'(misses), 32'd2);
        chk("respawn_live",   32'(live),   32'd1);
        step(8);                                          // c44
        chk("misses_3",   32'(misses), 32'd3);
        chk("live_c44",   32'(live),   32'd2);
        step(3);                                          // c47
        x5 = fx(m); y5 = fy(m);
        step(1);                                          // c48
        chk("misses_sat", 32'(misses), 32'd3);
        chk("live_c48",   32'(live),   32'd1);
        draw_done = 1'b0;
        step(1);                                          // c49
        chk("erase_stall_req",   32'(draw_req),   32'd1);
        chk("erase_stall_color", 32'(draw_color), 32'd0);
        click = 1'b1; click_x = x5; click_y = y5 + 11'd15;
        step(1);                                          // c50
        exp_score = sat_inc(exp_score);
        chk("score_sat_hit", 32'(hit),      32'd1);
        chk("score_sat",     32'(score),    32'(exp_score));
        chk("live_c50",      32'(live),     32'd0);
        chk("req_held",      32'(draw_req), 32'd1);

        click = 1'b0; reset = 1'b1; start = 1'b0;
        step(1);                                          // c51
        chk("midrst_req",    32'(draw_req), 32'd0);
        chk("midrst_score",  32'(score),    32'd0);
        chk("midrst_misses", 32'(misses),   32'd0);
        chk("midrst_live",   32'(live),     32'd0);
        chk("midrst_hit",    32'(hit),      32'd0);
        reset = 1'b0; draw_done = 1'b1;                   // stray completion
        step(1);
        draw_done = 1'b0;
        step(1);
        chk("stray_done_req", 32'(draw_req), 32'd0);
        chk("stray_done_live", 32'(live),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
